jt051937_draw: RTL

Sprite tile drawer that sits directly downstream of the jt053246 table scanner. On each `dr_start` it draws one 16-pixel-wide row slice of a 4bpp sprite tile. It fetches the row from graphics ROM, applies horizontal flip and horizontal zoom, and writes opaque pixels with their attribute into the object line buffer. `dr_busy` tells the scanner when it may issue the next tile.

---
 rtl/jt051937_draw.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/jt051937_draw.sv
// jt051937_draw: sprite row drawer fed by the jt053246 scanner.
// Each accepted dr_start fetches one 16-pixel 4bpp tile row from ROM
// as two 32-bit words, then emits one output pixel per cycle into the
// object line buffer. Horizontal zoom runs a 10.6 fixed-point source
// accumulator, and horizontal flip mirrors the source index. Pixel
// value 0 is transparent and is never written.
module jt051937_draw #(
  parameter int PW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           dr_start,
  output logic           dr_busy,
  input  logic [15:0]    code,
  input  logic [9:0]     attr,
  input  logic           hflip,
  input  logic           vflip,
  input  logic [8:0]     hpos,
  input  logic [3:0]     ysub,
  input  logic [11:0]    hzoom,
  input  logic           hz_keep,
  output logic [20:0]    rom_addr,
  output logic           rom_cs,
  input  logic           rom_ok,
  input  logic [31:0]    rom_data,
  output logic [8:0]     buf_addr,
  output logic           buf_we,
  output logic [PW+9:0]  buf_din
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH0 = 2'd1;
  localparam logic [1:0] ST_FETCH1 = 2'd2;
  localparam logic [1:0] ST_DRAW   = 2'd3;

  logic [1:0]    state_r;
  logic          first_r;     // first cycle of a ROM request: rom_ok not trusted
  logic [9:0]    attr_r;
  logic          hflip_r;
  logic [8:0]    hpos_r;
  logic [11:0]   step_r;
  logic          hz_keep_r;
  logic [5:0]    kept_frac_r; // zoom phase carried into the next tile
  logic [15:0]   acc_r;       // source position, 10.6 fixed point
  logic [8:0]    n_r;         // output pixel counter
  logic [63:0]   pix_row_r;   // nibble 0 sits in [63:60]
  logic [20:0]   rom_addr_r;
  logic          rom_cs_r;
  logic          busy_r;
  logic          buf_we_r;
  logic [8:0]    buf_addr_r;
  logic [PW+9:0] buf_din_r;

  logic [3:0]    sx_s;
  logic [63:0]   row_shift_s;
  logic [3:0]    pixel_s;
  logic [15:0]   acc_next_s;
  logic [8:0]    n_next_s;
  logic          draw_done_s;

  // Draw datapath: source nibble select, accumulator step and end-of-tile test
  always_comb begin
    sx_s        = acc_r[9:6] ^ {4{hflip_r}};
    row_shift_s = pix_row_r << {sx_s, 2'b00};
    pixel_s     = row_shift_s[63:60];
    acc_next_s  = acc_r + {4'd0, step_r};
    n_next_s    = n_r + 9'd1;
    draw_done_s = (acc_next_s >= 16'h0400) || (n_next_s == 9'd256);
  end

  // Control FSM plus all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      first_r     <= 1'b0;
      attr_r      <= 10'd0;
      hflip_r     <= 1'b0;
      hpos_r      <= 9'd0;
      step_r      <= 12'd0;
      hz_keep_r   <= 1'b0;
      kept_frac_r <= 6'd0;
      acc_r       <= 16'd0;
      n_r         <= 9'd0;
      pix_row_r   <= 64'd0;
      rom_addr_r  <= 21'd0;
      rom_cs_r    <= 1'b0;
      busy_r      <= 1'b0;
      buf_we_r    <= 1'b0;
      buf_addr_r  <= 9'd0;
      buf_din_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          buf_we_r <= 1'b0;
          if (dr_start) begin
            state_r    <= ST_FETCH0;
            busy_r     <= 1'b1;
            rom_cs_r   <= 1'b1;
            first_r    <= 1'b1;
            rom_addr_r <= {code, ysub ^ {4{vflip}}, 1'b0};
            attr_r     <= attr;
            hflip_r    <= hflip;
            hpos_r     <= hpos;
            step_r     <= (hzoom == 12'd0) ? 12'd1 : hzoom;
            hz_keep_r  <= hz_keep;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_FETCH0: begin
          buf_we_r <= 1'b0;
          if (first_r) begin
            first_r <= 1'b0;
          end else if (rom_ok) begin
            pix_row_r[63:32] <= rom_data;
            rom_addr_r[0]    <= 1'b1;
            first_r          <= 1'b1;
            state_r          <= ST_FETCH1;
          end
        end
        ST_FETCH1: begin
          buf_we_r <= 1'b0;
          if (first_r) begin
            first_r <= 1'b0;
          end else if (rom_ok) begin
            pix_row_r[31:0] <= rom_data;
            rom_cs_r        <= 1'b0;
            acc_r           <= hz_keep_r ? {10'd0, kept_frac_r} : 16'd0;
            n_r             <= 9'd0;
            state_r         <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          buf_we_r   <= (pixel_s != 4'd0);
          buf_addr_r <= hpos_r + n_r;
          buf_din_r  <= {attr_r, pixel_s};
          acc_r      <= acc_next_s;
          n_r        <= n_next_s;
          if (draw_done_s) begin
            kept_frac_r <= acc_next_s[5:0];
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          rom_cs_r <= 1'b0;
          buf_we_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign dr_busy  = busy_r;
  assign rom_cs   = rom_cs_r;
  assign rom_addr = rom_addr_r;
  assign buf_we   = buf_we_r;
  assign buf_addr = buf_addr_r;
  assign buf_din  = buf_din_r;

endmodule
